// File: rtl/traffic_pkg.sv
// Shared types and lamp decode for the two-way intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_NS_GREEN  = 3'd0,
    ST_NS_YELLOW = 3'd1,
    ST_ALLRED_1  = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_ALLRED_2  = 3'd5,
    ST_PED_WALK  = 3'd6,
    ST_FLASH     = 3'd7
  } tl_state_t;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } tl_lamp_t;

  typedef struct packed {
    tl_lamp_t ns;
    tl_lamp_t ew;
  } tl_heads_t;

  localparam tl_lamp_t LAMP_R = 3'b100;
  localparam tl_lamp_t LAMP_Y = 3'b010;
  localparam tl_lamp_t LAMP_G = 3'b001;

  // Lamp pattern for both heads given the state and the flash phase bit.
  function automatic tl_heads_t lamps_of(input tl_state_t st, input logic phase);
    tl_heads_t h;
    h.ns = LAMP_R;
    h.ew = LAMP_R;
    case (st)
      ST_NS_GREEN:  h.ns = LAMP_G;
      ST_NS_YELLOW: h.ns = LAMP_Y;
      ST_EW_GREEN:  h.ew = LAMP_G;
      ST_EW_YELLOW: h.ew = LAMP_Y;
      ST_FLASH: begin
        h.ns = tl_lamp_t'({phase, 2'b00});
        h.ew = tl_lamp_t'({phase, 2'b00});
      end
      default: ;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-driven dwell counter: done pulses on the tick that completes dur ticks.
module phase_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic [CNT_W-1:0] dur,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;

  assign done = tick && (r_cnt == (dur - CNT_W'(1)));

  // Count ticks; wrap to zero on expiry, clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear || done) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection controller with all-red clearance, pedestrian walk
// and flashing-red maintenance mode; all dwells counted in timebase ticks.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 20,
  parameter int unsigned YELLOW_TICKS = 4,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned PED_TICKS    = 10,
  parameter int unsigned FLASH_TICKS  = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic ped_req,
  input  logic flash_mode,
  output logic ns_r,
  output logic ns_y,
  output logic ns_g,
  output logic ew_r,
  output logic ew_y,
  output logic ew_g,
  output logic ped_walk,
  output logic ped_pend
);

  localparam logic [63:0] DUR_LIMIT = 64'd1 << CNT_W;

  // Reject counter widths that cannot hold a configured dwell.
  if (CNT_W < 1 || CNT_W > 63) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..63");
  end
  if (GREEN_TICKS < 1 || 64'(GREEN_TICKS) >= DUR_LIMIT) begin : g_bad_green
    $error("GREEN_TICKS out of range for CNT_W");
  end
  if (YELLOW_TICKS < 1 || 64'(YELLOW_TICKS) >= DUR_LIMIT) begin : g_bad_yellow
    $error("YELLOW_TICKS out of range for CNT_W");
  end
  if (ALLRED_TICKS < 1 || 64'(ALLRED_TICKS) >= DUR_LIMIT) begin : g_bad_allred
    $error("ALLRED_TICKS out of range for CNT_W");
  end
  if (PED_TICKS < 1 || 64'(PED_TICKS) >= DUR_LIMIT) begin : g_bad_ped
    $error("PED_TICKS out of range for CNT_W");
  end
  if (FLASH_TICKS < 1 || 64'(FLASH_TICKS) >= DUR_LIMIT) begin : g_bad_flash
    $error("FLASH_TICKS out of range for CNT_W");
  end

  tl_state_t        r_state;
  tl_state_t        w_state_nxt;
  logic             r_pend;
  logic             w_pend_nxt;
  logic             r_phase;
  logic             w_phase_nxt;
  logic             r_ret_ew;
  logic             w_ret_ew_nxt;
  logic             w_clear;
  logic             w_done;
  logic [CNT_W-1:0] w_dur;
  tl_heads_t        w_lamps;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .clear (w_clear),
    .dur   (w_dur),
    .done  (w_done)
  );

  // Dwell length of the current state.
  always_comb begin
    w_dur = CNT_W'(ALLRED_TICKS);
    case (r_state)
      ST_NS_GREEN, ST_EW_GREEN:   w_dur = CNT_W'(GREEN_TICKS);
      ST_NS_YELLOW, ST_EW_YELLOW: w_dur = CNT_W'(YELLOW_TICKS);
      ST_PED_WALK:                w_dur = CNT_W'(PED_TICKS);
      ST_FLASH:                   w_dur = CNT_W'(FLASH_TICKS);
      default:                    w_dur = CNT_W'(ALLRED_TICKS);
    endcase
  end

  // Next-state logic: flash mode first, then flash exit, then phase expiry.
  always_comb begin
    w_state_nxt  = r_state;
    w_pend_nxt   = r_pend;
    w_phase_nxt  = r_phase;
    w_ret_ew_nxt = r_ret_ew;
    w_clear      = 1'b0;
    if (flash_mode) begin
      w_state_nxt = ST_FLASH;
      w_pend_nxt  = 1'b0;
      if (r_state != ST_FLASH) begin
        w_clear     = 1'b1;
        w_phase_nxt = 1'b1;
      end else if (w_done) begin
        w_phase_nxt = ~r_phase;
      end
    end else if (r_state == ST_FLASH) begin
      w_state_nxt = ST_ALLRED_2;
      w_clear     = 1'b1;
    end else begin
      if (ped_req && r_state != ST_PED_WALK) begin
        w_pend_nxt = 1'b1;
      end
      if (w_done) begin
        case (r_state)
          ST_NS_GREEN:  w_state_nxt = ST_NS_YELLOW;
          ST_NS_YELLOW: w_state_nxt = ST_ALLRED_1;
          ST_ALLRED_1: begin
            if (r_pend) begin
              w_state_nxt  = ST_PED_WALK;
              w_ret_ew_nxt = 1'b1;
              w_pend_nxt   = 1'b0;
            end else begin
              w_state_nxt = ST_EW_GREEN;
            end
          end
          ST_EW_GREEN:  w_state_nxt = ST_EW_YELLOW;
          ST_EW_YELLOW: w_state_nxt = ST_ALLRED_2;
          ST_ALLRED_2: begin
            if (r_pend) begin
              w_state_nxt  = ST_PED_WALK;
              w_ret_ew_nxt = 1'b0;
              w_pend_nxt   = 1'b0;
            end else begin
              w_state_nxt = ST_NS_GREEN;
            end
          end
          ST_PED_WALK:  w_state_nxt = r_ret_ew ? ST_EW_GREEN : ST_NS_GREEN;
          default:      w_state_nxt = ST_ALLRED_2;
        endcase
      end
    end
  end

  // State, pending-request, flash-phase and return-direction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_ALLRED_2;
      r_pend   <= 1'b0;
      r_phase  <= 1'b1;
      r_ret_ew <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pend   <= w_pend_nxt;
      r_phase  <= w_phase_nxt;
      r_ret_ew <= w_ret_ew_nxt;
    end
  end

  assign w_lamps  = lamps_of(r_state, r_phase);
  assign ns_r     = w_lamps.ns.r;
  assign ns_y     = w_lamps.ns.y;
  assign ns_g     = w_lamps.ns.g;
  assign ew_r     = w_lamps.ew.r;
  assign ew_y     = w_lamps.ew.y;
  assign ew_g     = w_lamps.ew.g;
  assign ped_walk = (r_state == ST_PED_WALK);
  assign ped_pend = r_pend;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed and randomised checks of the intersection controller.
module tb_traffic_intersection_ctrl;
  import traffic_pkg::*;

  localparam int unsigned T_GREEN  = 5;
  localparam int unsigned T_YELLOW = 2;
  localparam int unsigned T_ALLRED = 1;
  localparam int unsigned T_PED    = 3;
  localparam int unsigned T_FLASH  = 2;

  // Lamp patterns {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g}.
  localparam logic [5:0] L_NSG = 6'b001100;
  localparam logic [5:0] L_NSY = 6'b010100;
  localparam logic [5:0] L_AR  = 6'b100100;
  localparam logic [5:0] L_EWG = 6'b100001;
  localparam logic [5:0] L_EWY = 6'b100010;
  localparam logic [5:0] L_OFF = 6'b000000;

  logic clk, rst, tick, ped_req, flash_mode;
  logic ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk, ped_pend;

  int n_pass  = 0;
  int n_total = 0;

  traffic_intersection_ctrl #(
    .GREEN_TICKS  (T_GREEN),
    .YELLOW_TICKS (T_YELLOW),
    .ALLRED_TICKS (T_ALLRED),
    .PED_TICKS    (T_PED),
    .FLASH_TICKS  (T_FLASH),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .ped_req    (ped_req),
    .flash_mode (flash_mode),
    .ns_r       (ns_r),
    .ns_y       (ns_y),
    .ns_g       (ns_g),
    .ew_r       (ew_r),
    .ew_y       (ew_y),
    .ew_g       (ew_g),
    .ped_walk   (ped_walk),
    .ped_pend   (ped_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {lamps, ped_walk, ped_pend}
  function automatic logic [7:0] outs();
    return {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk, ped_pend};
  endfunction

  // Expected lamps k cycles after reset release with tick held high.
  function automatic logic [5:0] exp_cycle(input int k);
    int p;
    p = (k - 1) % 16;
    if (p < 5)       return L_NSG;
    else if (p < 7)  return L_NSY;
    else if (p == 7) return L_AR;
    else if (p < 13) return L_EWG;
    else if (p < 15) return L_EWY;
    else             return L_AR;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; tick = 1'b1; ped_req = 1'b0; flash_mode = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    rst = 1'b0; tick = 1'b1; ped_req = 1'b1; flash_mode = 1'b0;
    step();
    step();
    o = outs();
    n_total++;
    if (o !== {L_AR, 2'b00}) $display("FAIL reset_held got=%b want=%b", o, {L_AR, 2'b00});
    else n_pass++;
    ped_req = 1'b0;
    rst = 1'b1;
    #1;
    o = outs();
    n_total++;
    if (o !== {L_AR, 2'b00}) $display("FAIL reset_release got=%b want=%b", o, {L_AR, 2'b00});
    else n_pass++;
  endtask

  task automatic test_normal_cycle();
    logic [7:0] o;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      step();
      o = outs();
      n_total++;
      if (o !== {exp_cycle(k), 2'b00}) $display("FAIL normal_k%0d got=%b want=%b", k, o, {exp_cycle(k), 2'b00});
      else n_pass++;
    end
  endtask

  task automatic test_ped_walk();
    logic [7:0] o;
    logic [7:0] exp_tab [13];
    exp_tab = '{{L_NSG, 2'b00}, {L_NSG, 2'b01}, {L_NSG, 2'b01}, {L_NSG, 2'b01},
                {L_NSG, 2'b01}, {L_NSY, 2'b01}, {L_NSY, 2'b01}, {L_AR, 2'b01},
                {L_AR, 2'b10},  {L_AR, 2'b10},  {L_AR, 2'b10},  {L_EWG, 2'b00},
                {L_EWG, 2'b00}};
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      step();
      o = outs();
      n_total++;
      if (o !== exp_tab[k-1]) $display("FAIL ped_k%0d got=%b want=%b", k, o, exp_tab[k-1]);
      else n_pass++;
      ped_req = (k == 1);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_tick_rate();
    logic [7:0] o;
    int n_g, n_y, first_y;
    n_g = 0; n_y = 0; first_y = -1;
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      tick = ((e - 1) % 3 == 0);
      step();
      o = outs();
      if (o[7:2] == L_NSG) n_g++;
      if (o[7:2] == L_NSY) begin
        n_y++;
        if (first_y < 0) first_y = e;
      end
      if (e == 22) begin
        n_total++;
        if (o[7:2] !== L_AR) $display("FAIL tick_allred1 got=%b want=%b", o[7:2], L_AR);
        else n_pass++;
      end
    end
    tick = 1'b1;
    n_total++;
    if (n_g != 15) $display("FAIL tick_green_len got=%0d want=15", n_g);
    else n_pass++;
    n_total++;
    if (n_y != 6) $display("FAIL tick_yellow_len got=%0d want=6", n_y);
    else n_pass++;
    n_total++;
    if (first_y != 16) $display("FAIL tick_yellow_start got=%0d want=16", first_y);
    else n_pass++;
  endtask

  task automatic test_flash();
    logic [7:0] o;
    logic [7:0] want;
    do_reset();
    for (int s = 1; s <= 10; s++) step();
    o = outs();
    n_total++;
    if (o !== {L_EWG, 2'b00}) $display("FAIL flash_pre got=%b want=%b", o, {L_EWG, 2'b00});
    else n_pass++;
    flash_mode = 1'b1;
    ped_req = 1'b1;
    for (int s = 11; s <= 18; s++) begin
      step();
      o = outs();
      want = (((s - 11) / 2) % 2 == 0) ? {L_AR, 2'b00} : {L_OFF, 2'b00};
      n_total++;
      if (o !== want) $display("FAIL flash_s%0d got=%b want=%b", s, o, want);
      else n_pass++;
    end
    flash_mode = 1'b0;
    ped_req = 1'b0;
    step();
    o = outs();
    n_total++;
    if (o !== {L_AR, 2'b00}) $display("FAIL flash_exit got=%b want=%b", o, {L_AR, 2'b00});
    else n_pass++;
    step();
    o = outs();
    n_total++;
    if (o !== {L_NSG, 2'b00}) $display("FAIL flash_resume got=%b want=%b", o, {L_NSG, 2'b00});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [7:0] o;
    do_reset();
    for (int s = 1; s <= 6; s++) begin
      step();
      ped_req = (s == 1);
    end
    ped_req = 1'b0;
    o = outs();
    n_total++;
    if (o !== {L_NSY, 2'b01}) $display("FAIL areset_pre got=%b want=%b", o, {L_NSY, 2'b01});
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    o = outs();
    n_total++;
    if (o !== {L_AR, 2'b00}) $display("FAIL areset_immediate got=%b want=%b", o, {L_AR, 2'b00});
    else n_pass++;
    step();
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      o = outs();
      n_total++;
      if (o !== {exp_cycle(k), 2'b00}) $display("FAIL areset_k%0d got=%b want=%b", k, o, {exp_cycle(k), 2'b00});
      else n_pass++;
    end
  endtask

  // Reference model state for the randomised run.
  tl_state_t m_st;
  int        m_cnt;
  logic      m_pend, m_phase, m_ret_ew;

  function automatic int m_dur(input tl_state_t s);
    case (s)
      ST_NS_GREEN, ST_EW_GREEN:   return T_GREEN;
      ST_NS_YELLOW, ST_EW_YELLOW: return T_YELLOW;
      ST_PED_WALK:                return T_PED;
      ST_FLASH:                   return T_FLASH;
      default:                    return T_ALLRED;
    endcase
  endfunction

  task automatic model_step(input logic tk, input logic pr, input logic fm);
    tl_state_t s;
    logic      p;
    s = m_st;
    p = m_pend;
    if (fm) begin
      if (m_st != ST_FLASH) begin
        m_cnt = 0;
        m_phase = 1'b1;
      end else if (tk) begin
        if (m_cnt == T_FLASH - 1) begin
          m_cnt = 0;
          m_phase = ~m_phase;
        end else m_cnt++;
      end
      s = ST_FLASH;
      p = 1'b0;
    end else if (m_st == ST_FLASH) begin
      s = ST_ALLRED_2;
      m_cnt = 0;
    end else begin
      if (pr && m_st != ST_PED_WALK) p = 1'b1;
      if (tk) begin
        if (m_cnt == m_dur(m_st) - 1) begin
          m_cnt = 0;
          unique case (m_st)
            ST_NS_GREEN:  s = ST_NS_YELLOW;
            ST_NS_YELLOW: s = ST_ALLRED_1;
            ST_EW_GREEN:  s = ST_EW_YELLOW;
            ST_EW_YELLOW: s = ST_ALLRED_2;
            ST_ALLRED_1: begin
              if (m_pend) begin s = ST_PED_WALK; m_ret_ew = 1'b1; p = 1'b0; end
              else s = ST_EW_GREEN;
            end
            ST_ALLRED_2: begin
              if (m_pend) begin s = ST_PED_WALK; m_ret_ew = 1'b0; p = 1'b0; end
              else s = ST_NS_GREEN;
            end
            default: s = m_ret_ew ? ST_EW_GREEN : ST_NS_GREEN;
          endcase
        end else m_cnt++;
      end
    end
    m_st = s;
    m_pend = p;
  endtask

  task automatic test_random();
    logic [7:0] o, prev, want;
    tl_heads_t  h;
    logic       inv_ok;
    do_reset();
    m_st = ST_ALLRED_2; m_cnt = 0; m_pend = 1'b0; m_phase = 1'b1; m_ret_ew = 1'b0;
    prev = outs();
    for (int c = 0; c < 4000; c++) begin
      tick = ($urandom_range(0, 3) != 0);
      ped_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) flash_mode = ~flash_mode;
      model_step(tick, ped_req, flash_mode);
      step();
      o = outs();
      h = lamps_of(m_st, m_phase);
      want = {h, m_st == ST_PED_WALK, m_pend};
      n_total++;
      if (o !== want) $display("FAIL rand_model c%0d got=%b want=%b", c, o, want);
      else n_pass++;
      if (m_st != ST_FLASH) begin
        inv_ok = ($countones(o[7:5]) == 1) && ($countones(o[4:2]) == 1) &&
                 (o[7] || o[4]) && (!o[1] || (o[7] && o[4])) &&
                 (!(o[5] && !prev[5]) || (prev[7] && prev[4])) &&
                 (!(o[2] && !prev[2]) || (prev[7] && prev[4]));
        n_total++;
        if (!inv_ok) $display("FAIL rand_invariant c%0d got=%b prev=%b", c, o, prev);
        else n_pass++;
      end
      prev = o;
    end
    flash_mode = 1'b0;
    ped_req = 1'b0;
    tick = 1'b1;
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; ped_req = 1'b0; flash_mode = 1'b0;
    test_reset();
    test_normal_cycle();
    test_ped_walk();
    test_tick_rate();
    test_flash();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
